// File: rtl/pc_sequencer.sv
// Program-counter / fetch sequencer: holds the PC, picks the next fetch address from
// the sequential, branch and jump paths, and runs the IDLE/RUN/HALT control FSM.
module pc_sequencer #(
  parameter int PC_W         = 3,
  parameter int OFF_W        = 7,
  parameter int CNT_W        = 8,
  parameter int RESET_PC     = 0,
  parameter bit HALT_ON_WRAP = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stall,
  input  logic             i_halt_req,
  input  logic             i_sig_branch,
  input  logic             i_zero_flag,
  input  logic             i_sig_jump,
  input  logic [OFF_W-1:0] i_branch_off,
  input  logic [PC_W-1:0]  i_jump_target,
  output logic [PC_W-1:0]  o_pc,
  output logic             o_pc_valid,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_instr_count
);

  // One guard bit above the wider operand keeps the dropped high part non-empty.
  localparam int EXT_W = ((OFF_W > PC_W) ? OFF_W : PC_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic             r_halted;
  logic [CNT_W-1:0] r_count;

  logic [PC_W-1:0]          w_pcInc;
  logic [EXT_W-1:0]         w_branchSum;
  logic [PC_W-1:0]          w_branchPc;
  logic [EXT_W-1:PC_W]      w_unusedHi;
  logic                     w_atMax;
  logic                     w_retire;

  assign w_pcInc     = r_pc + PC_W'(1);
  assign w_branchSum = EXT_W'(r_pc) + EXT_W'(1) + EXT_W'($signed(i_branch_off));
  assign w_branchPc  = w_branchSum[PC_W-1:0];
  assign w_unusedHi  = w_branchSum[EXT_W-1:PC_W];
  assign w_atMax     = (r_pc == {PC_W{1'b1}});
  assign w_retire    = (r_state == S_RUN) && !i_stall;

  // Priority on a retire: halt request, jump, taken branch, then sequential.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= PC_W'(RESET_PC);
      r_halted <= 1'b0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pc <= PC_W'(RESET_PC);
          if (i_start) r_state <= S_RUN;
        end
        S_RUN: begin
          if (!i_stall) begin
            if (r_count != {CNT_W{1'b1}}) r_count <= r_count + CNT_W'(1);
            if (i_halt_req) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else if (i_sig_jump) begin
              r_pc <= i_jump_target;
            end else if (i_sig_branch && i_zero_flag) begin
              r_pc <= w_branchPc;
            end else if (w_atMax && HALT_ON_WRAP) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc <= w_pcInc;
            end
          end
        end
        S_HALT: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= S_IDLE;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign o_pc          = r_pc;
  assign o_pc_valid    = w_retire;
  assign o_halted      = r_halted;
  assign o_instr_count = r_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: two instances (default, and CNT_W=3 with
// HALT_ON_WRAP=1) share stimulus and are compared against an integer reference model.
module tb_pc_sequencer;

  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_HALT = 2;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       haltReq = 1'b0;
  logic       sigBranch = 1'b0;
  logic       zeroFlag = 1'b0;
  logic       sigJump = 1'b0;
  logic [6:0] branchOff = '0;
  logic [2:0] jumpTarget = '0;

  logic [2:0] pcA, pcB;
  logic       validA, validB, haltedA, haltedB;
  logic [7:0] cntA;
  logic [2:0] cntB;

  int checks = 0;
  int errors = 0;

  int mState [2];
  int mPc    [2];
  int mCnt   [2];
  int cntMax   [2] = '{255, 7};
  int wrapHalt [2] = '{0, 1};

  pc_sequencer dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_stall(stall),
    .i_halt_req(haltReq), .i_sig_branch(sigBranch), .i_zero_flag(zeroFlag),
    .i_sig_jump(sigJump), .i_branch_off(branchOff), .i_jump_target(jumpTarget),
    .o_pc(pcA), .o_pc_valid(validA), .o_halted(haltedA), .o_instr_count(cntA)
  );

  pc_sequencer #(.CNT_W(3), .HALT_ON_WRAP(1'b1)) dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_stall(stall),
    .i_halt_req(haltReq), .i_sig_branch(sigBranch), .i_zero_flag(zeroFlag),
    .i_sig_jump(sigJump), .i_branch_off(branchOff), .i_jump_target(jumpTarget),
    .o_pc(pcB), .o_pc_valid(validB), .o_halted(haltedB), .o_instr_count(cntB)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    for (int k = 0; k < 2; k++) begin
      mState[k] = ST_IDLE;
      mPc[k]    = 0;
      mCnt[k]   = 0;
    end
  endfunction

  // Next-state rules written directly from the PC selection priorities, in plain integers.
  function automatic void modelStep();
    int off;
    off = branchOff[6] ? int'(branchOff) - 128 : int'(branchOff);
    for (int k = 0; k < 2; k++) begin
      if (!rstN) begin
        mState[k] = ST_IDLE; mPc[k] = 0; mCnt[k] = 0;
      end else if (mState[k] == ST_IDLE) begin
        mPc[k] = 0;
        if (start) mState[k] = ST_RUN;
      end else if (mState[k] == ST_RUN && !stall) begin
        if (mCnt[k] < cntMax[k]) mCnt[k]++;
        if (haltReq) mState[k] = ST_HALT;
        else if (sigJump) mPc[k] = int'(jumpTarget);
        else if (sigBranch && zeroFlag) mPc[k] = (((mPc[k] + 1 + off) % 8) + 8) % 8;
        else if (mPc[k] == 7 && wrapHalt[k] == 1) mState[k] = ST_HALT;
        else mPc[k] = (mPc[k] + 1) % 8;
      end
    end
  endfunction

  function automatic logic [12:0] observed(int k);
    if (k == 0) return {pcA, validA, haltedA, cntA};
    return {pcB, validB, haltedB, 5'b0, cntB};
  endfunction

  function automatic logic [12:0] expected(int k);
    logic v, h;
    v = (mState[k] == ST_RUN) && !stall;
    h = (mState[k] == ST_HALT);
    return {3'(mPc[k]), v, h, 8'(mCnt[k])};
  endfunction

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic clearInputs();
    start = 0; stall = 0; haltReq = 0; sigBranch = 0; zeroFlag = 0; sigJump = 0;
    branchOff = '0; jumpTarget = '0;
  endtask

  task automatic doReset();
    clearInputs();
    rstN = 1'b0;
    modelReset();
    tick();
    tick();
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    modelReset();
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (observed(k) !== expected(k)) begin
        errors++;
        $display("[TB] FAIL reset_async dut%0d: {pc,valid,halted,cnt} got %h expected %h", k, observed(k), expected(k));
      end
    end
    tick();
    rstN = 1'b1;
    for (int c = 0; c < 5; c++) begin
      start = 0; stall = 1'($urandom); haltReq = 1'($urandom); sigBranch = 1'($urandom);
      zeroFlag = 1'($urandom); sigJump = 1'($urandom);
      branchOff = 7'($urandom); jumpTarget = 3'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (observed(k) !== expected(k)) begin
          errors++;
          $display("[TB] FAIL reset_idle dut%0d cyc%0d: got %h expected %h", k, c, observed(k), expected(k));
        end
      end
    end
  endtask

  task automatic test_sequential();
    doReset();
    start = 1;
    for (int c = 0; c < 11; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (observed(k) !== expected(k)) begin
          errors++;
          $display("[TB] FAIL sequential dut%0d cyc%0d: got %h expected %h", k, c, observed(k), expected(k));
        end
      end
    end
    checks++;
    if (pcA !== 3'd2 || cntA !== 8'd10) begin
      errors++;
      $display("[TB] FAIL seq_wrap_total: pc=%0d cnt=%0d, expected pc=2 cnt=10", pcA, cntA);
    end
  endtask

  task automatic test_branch();
    doReset();
    start = 1;
    repeat (3) tick();
    sigBranch = 1; zeroFlag = 1; branchOff = 7'h7F;
    tick();
    checks++;
    if (pcA !== 3'd2) begin errors++; $display("[TB] FAIL branch_back: pc=%0d expected 2", pcA); end
    zeroFlag = 0;
    tick();
    checks++;
    if (pcA !== 3'd3) begin errors++; $display("[TB] FAIL branch_not_taken: pc=%0d expected 3", pcA); end
    sigBranch = 0;
    repeat (3) tick();
    sigBranch = 1; zeroFlag = 1; branchOff = 7'd5;
    tick();
    checks++;
    if (pcA !== 3'd4) begin errors++; $display("[TB] FAIL branch_fwd_wrap: pc=%0d expected 4", pcA); end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (observed(k) !== expected(k)) begin
        errors++;
        $display("[TB] FAIL branch_model dut%0d: got %h expected %h", k, observed(k), expected(k));
      end
    end
  endtask

  task automatic test_jump();
    doReset();
    start = 1;
    repeat (2) tick();
    sigJump = 1; jumpTarget = 3'd6; sigBranch = 1; zeroFlag = 1; branchOff = 7'd2;
    tick();
    checks++;
    if (pcA !== 3'd6 || cntA !== 8'd2) begin
      errors++;
      $display("[TB] FAIL jump_priority: pc=%0d cnt=%0d, expected pc=6 cnt=2", pcA, cntA);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (observed(k) !== expected(k)) begin
        errors++;
        $display("[TB] FAIL jump_model dut%0d: got %h expected %h", k, observed(k), expected(k));
      end
    end
  endtask

  task automatic test_stall_halt();
    doReset();
    start = 1;
    repeat (3) tick();
    stall = 1; haltReq = 1; sigJump = 1; jumpTarget = 3'd5;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (pcA !== 3'd2 || cntA !== 8'd2 || validA !== 1'b0 || haltedA !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold cyc%0d: pc=%0d cnt=%0d valid=%0b halted=%0b", c, pcA, cntA, validA, haltedA);
      end
    end
    stall = 0;
    tick();
    checks++;
    if (haltedA !== 1'b1 || cntA !== 8'd3 || pcA !== 3'd2 || validA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_entry: halted=%0b cnt=%0d pc=%0d valid=%0b, expected 1,3,2,0", haltedA, cntA, pcA, validA);
    end
    haltReq = 0; sigJump = 0; start = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (observed(k) !== expected(k)) begin
          errors++;
          $display("[TB] FAIL halt_sticky dut%0d cyc%0d: got %h expected %h", k, c, observed(k), expected(k));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    doReset();
    start = 1;
    repeat (6) tick();
    #3;
    rstN = 1'b0;
    modelReset();
    #1;
    checks++;
    if (pcA !== 3'd0 || validA !== 1'b0 || haltedA !== 1'b0 || cntA !== 8'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: pc=%0d valid=%0b halted=%0b cnt=%0d, expected all 0", pcA, validA, haltedA, cntA);
    end
    tick();
    rstN = 1'b1; start = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (observed(k) !== expected(k)) begin
          errors++;
          $display("[TB] FAIL post_reset_idle dut%0d: got %h expected %h", k, observed(k), expected(k));
        end
      end
    end
  endtask

  task automatic test_saturation_wrap();
    doReset();
    start = 1;
    tick();
    sigJump = 1;
    for (int c = 0; c < 12; c++) begin
      jumpTarget = 3'($urandom_range(0, 6));
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (observed(k) !== expected(k)) begin
          errors++;
          $display("[TB] FAIL saturate dut%0d cyc%0d: got %h expected %h", k, c, observed(k), expected(k));
        end
      end
    end
    checks++;
    if (cntB !== 3'd7 || cntA !== 8'd12 || haltedB !== 1'b0) begin
      errors++;
      $display("[TB] FAIL saturate_total: cntB=%0d cntA=%0d haltedB=%0b, expected 7,12,0", cntB, cntA, haltedB);
    end
    jumpTarget = 3'd7;
    tick();
    sigJump = 0;
    tick();
    checks++;
    if (haltedB !== 1'b1 || pcB !== 3'd7 || pcA !== 3'd0 || haltedA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_policy: haltedB=%0b pcB=%0d pcA=%0d haltedA=%0b, expected 1,7,0,0", haltedB, pcB, pcA, haltedA);
    end
  endtask

  task automatic test_random();
    doReset();
    for (int c = 0; c < 400; c++) begin
      rstN = ($urandom_range(0, 59) != 0);
      if (!rstN) modelReset();
      start = ($urandom_range(0, 3) == 0);
      stall = ($urandom_range(0, 3) == 0);
      haltReq = ($urandom_range(0, 19) == 0);
      sigBranch = ($urandom_range(0, 2) == 0);
      zeroFlag = 1'($urandom);
      sigJump = ($urandom_range(0, 4) == 0);
      branchOff = 7'($urandom);
      jumpTarget = 3'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (observed(k) !== expected(k)) begin
          errors++;
          $display("[TB] FAIL random dut%0d cyc%0d: got %h expected %h", k, c, observed(k), expected(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall_halt();
    test_async_reset();
    test_saturation_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
